dm_store_buffer: RTL and testbench

DM_STORE_BUFFER -- requirements
Module: dm_store_buffer

---
 rtl/dm_store_buffer.sv | 109 ++++++++++
 tb/tb_dm_store_buffer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/dm_store_buffer.sv
// Store buffer between CPU and data memory: FIFO of pending word stores with load-hit detection.
// Latency: a store enqueues on the clock edge and is presented to memory the next cycle.
// Backpressure: cpu_stall when storing into a full buffer or loading a word that is still pending.
module dm_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cpu_we,
    input  logic                       cpu_re,
    input  logic [31:0]                cpu_addr,
    input  logic [31:0]                cpu_wdata,
    input  logic [3:0]                 cpu_be,
    output logic                       cpu_stall,
    output logic                       dm_we,
    output logic [29:0]                dm_addr,
    output logic [31:0]                dm_din,
    output logic [3:0]                 dm_be,
    input  logic                       dm_ready,
    output logic                       sb_empty,
    output logic [$clog2(DEPTH):0]     sb_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [29:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [3:0]    be_q   [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic full, empty, hit_any, load_hit, load_own, enq, deq;
    logic unused_addr_lsb;

    // Byte offset is irrelevant: matching and memory access are word-granular.
    assign unused_addr_lsb = ^cpu_addr[1:0];

    // Hit detection, port arbitration and stall; stall never looks at dm_ready.
    always_comb begin
        full    = (count_q == CW'(DEPTH));
        empty   = (count_q == '0);
        hit_any = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (addr_q[i] == cpu_addr[31:2])) begin
                hit_any = 1'b1;
            end
        end
        load_hit  = cpu_re && !cpu_we && hit_any;
        load_own  = cpu_re && !cpu_we && !hit_any;
        cpu_stall = (cpu_we && full) || load_hit;
        dm_we     = !reset && !load_own && !empty;
        dm_addr   = dm_we ? addr_q[head_q] : cpu_addr[31:2];
        dm_din    = data_q[head_q];
        dm_be     = be_q[head_q];
        sb_empty  = reset || empty;
        sb_count  = reset ? '0 : count_q;
        enq       = cpu_we && !full;
        deq       = dm_we && dm_ready;
    end

    // Next-state for pointers, occupancy and per-entry valid bits.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        vld_d   = vld_q;
        if (deq) begin
            head_d        = head_q + AW'(1);
            vld_d[head_q] = 1'b0;
        end
        if (enq) begin
            tail_d        = tail_q + AW'(1);
            vld_d[tail_q] = 1'b1;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset overrides any simultaneous store or drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
        end
    end

    // Entry payload; contents are meaningless unless the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (enq && !reset) begin
            addr_q[tail_q] <= cpu_addr[31:2];
            data_q[tail_q] <= cpu_wdata;
            be_q[tail_q]   <= cpu_be;
        end
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
module tb_dm_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, cpu_we, cpu_re, dm_ready;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_be;
    logic        cpu_stall, dm_we, sb_empty;
    logic [29:0] dm_addr;
    logic [31:0] dm_din;
    logic [3:0]  dm_be;
    logic [2:0]  sb_count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
        logic [3:0]  b;
    } ent_t;

    ent_t q[$];

    dm_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
        .cpu_stall(cpu_stall), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_din(dm_din), .dm_be(dm_be), .dm_ready(dm_ready),
        .sb_empty(sb_empty), .sb_count(sb_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic we, input logic re, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be, input logic rdy);
        reset = rst; cpu_we = we; cpu_re = re; cpu_addr = addr;
        cpu_wdata = wd; cpu_be = be; dm_ready = rdy;
    endtask

    // One cycle: apply inputs, compare against the queue model mid-cycle, advance the model.
    task automatic step(input logic rst, input logic we, input logic re, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input logic rdy);
        bit full, empty, hit, own, exp_we, exp_stall;
        drive(rst, we, re, addr, wd, be, rdy);
        @(negedge clk);
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        hit   = 1'b0;
        foreach (q[i]) if (q[i].a == addr[31:2]) hit = 1'b1;
        exp_stall = (we && full) || (re && !we && hit);
        own       = re && !we && !hit;
        exp_we    = !rst && !own && !empty;
        check("stall", cpu_stall, exp_stall);
        check("dm_we", dm_we, exp_we);
        check("count", sb_count, rst ? 0 : q.size());
        check("empty", sb_empty, rst ? 1'b1 : empty);
        if (exp_we) begin
            check("head_addr", dm_addr, q[0].a);
            check("head_data", dm_din, q[0].d);
            check("head_be", dm_be, q[0].b);
        end else if (!rst) begin
            check("port_addr", dm_addr, addr[31:2]);
        end
        if (rst) begin
            q.delete();
        end else begin
            if (exp_we && rdy) void'(q.pop_front());
            if (we && !full) q.push_back('{a: addr[31:2], d: wd, b: be});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        #1;
        check("rst_empty", sb_empty, 1'b1);
        check("rst_we", dm_we, 1'b0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1);
        check("post_rst_count", sb_count, 0);

        // Single store drains the following cycle.
        step(0, 1, 0, 32'h100, 32'hDEADBEEF, 4'hF, 1);
        drive(0, 0, 0, 0, 0, 0, 1); #1;
        check("single_we", dm_we, 1'b1);
        check("single_addr", dm_addr, 30'h40);
        check("single_din", dm_din, 32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 1); #1;
        check("single_empty", sb_empty, 1'b1);

        // Fill to full with memory stalled; fifth store is refused until a slot frees.
        for (int i = 0; i < 4; i++) step(0, 1, 0, 32'h1000 + 32'(i * 4), 32'hA0 + 32'(i), 4'(i + 1), 0);
        drive(0, 1, 0, 32'h1010, 32'hA4, 4'h5, 0); #1;
        check("full_stall", cpu_stall, 1'b1);
        check("full_count", sb_count, 3'd4);
        step(0, 1, 0, 32'h1010, 32'hA4, 4'h5, 0);
        step(0, 1, 0, 32'h1010, 32'hA4, 4'h5, 1);
        step(0, 1, 0, 32'h1010, 32'hA4, 4'h5, 0);
        check("fifth_in", sb_count, 3'd4);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 1);

        // Load hit on a pending word stalls until it has drained.
        step(0, 1, 0, 32'h200, 32'h12345678, 4'h3, 0);
        drive(0, 0, 1, 32'h203, 0, 0, 0); #1;
        check("hit_stall", cpu_stall, 1'b1);
        step(0, 0, 1, 32'h203, 0, 0, 0);
        step(0, 0, 1, 32'h203, 0, 0, 1);
        drive(0, 0, 1, 32'h203, 0, 0, 0); #1;
        check("hit_release", cpu_stall, 1'b0);
        check("hit_ld_addr", dm_addr, 30'h80);
        check("hit_ld_we", dm_we, 1'b0);
        step(0, 0, 1, 32'h203, 0, 0, 0);

        // Load miss owns the port while stores wait.
        step(0, 1, 0, 32'h400, 32'h1, 4'h1, 0);
        step(0, 1, 0, 32'h404, 32'h2, 4'h2, 0);
        drive(0, 0, 1, 32'h300, 0, 0, 1); #1;
        check("miss_stall", cpu_stall, 1'b0);
        check("miss_we", dm_we, 1'b0);
        check("miss_addr", dm_addr, 30'hC0);
        step(0, 0, 1, 32'h300, 0, 0, 1);
        check("miss_count", sb_count, 3'd2);

        // Reset mid-drain discards everything pending.
        step(0, 1, 0, 32'h408, 32'h3, 4'h4, 0);
        step(1, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 1); #1;
        check("rst_drain_count", sb_count, 0);
        check("rst_drain_we", dm_we, 1'b0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1);

        // Ten stores with alternating ready exercise wrap and simultaneous enq/deq.
        for (int i = 0; i < 10; i++) step(0, 1, 0, 32'h2000 + 32'(i * 4), $urandom, 4'(i), 1'(i % 2 == 0));
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0, 1);

        // Randomized traffic over a small address pool so loads hit often.
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a;
            a = 32'h3000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 3),
                 a, $urandom, 4'($urandom), ($urandom_range(0, 1) == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
